fft_pass_scheduler: RTL and testbench
=====================================

// Module: fft_pass_scheduler
// PURPOSE
//  Sequencing controller for the mixed-radix (2^a*3^b*5^c) FFT datapath. On a start pulse it factorises
//  the requested size N = n_last+1, publishes the per-radix stage counts and issues one pass command per
//  radix stage (all radix-5, then radix-3, then radix-2). Between commands it waits for the engine's pass
//  completion and supervises it with a watchdog. Sits between the slot-level control and the FFT engines.
// PARAMETERS
//  N_W      11    width of n_last. Max N = 2^N_W.
//  TO_W     13    watchdog counter width.
//  TIMEOUT  4096  cycles allowed per pass before it is aborted. Must be < 2^TO_W.
// PORTS
//  clk        in   1     system clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  start      in   1     1-cycle request. Sampled only in IDLE.
//  n_last     in   N_W   last sample address. N = n_last+1. Sampled with start.
//  eng_done   in   1     1-cycle pulse from the engine: current pass finished
//  busy       out  1     job in progress
//  stage2     out  4     number of radix-2 stages
//  stage3     out  3     number of radix-3 stages
//  stage5     out  2     number of radix-5 stages
//  pass_start out  1     1-cycle pulse: engine begins a pass
//  pass_radix out  2     00 none, 01 r2, 10 r3, 11 r5. Held for the whole pass.
//  pass_idx   out  4     0-based index of the current pass
//  fft_done   out  1     1-cycle pulse: all passes complete
//  err        out  1     1-cycle pulse: bad size or watchdog expiry
// BEHAVIOUR
//  Reset: all outputs 0. FSM is in IDLE. Residual m, counters and watchdog are cleared.
//  FSM states: IDLE -> LOAD -> FACTOR -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  IDLE:   on start, capture m = n_last+1 (N_W+1 bits) and clear the stage counts. Go to LOAD.
//          busy goes to 1 on the next cycle.
//  FACTOR: strip one factor per cycle, in priority order:
//          - m even: m = m>>1, stage2++
//          - else m%3==0: m = m/3, stage3++
//          - else m%5==0: m = m/5, stage5++
//          - else factoring ends.
//          Factoring therefore takes a+b+c+1 cycles after LOAD.
//  Error cases, checked when factoring ends:
//          - m != 1, or N == 1
//          - stage5 would exceed 3: a 4th radix-5 strip is an error. Detected at strip time; stage5 saturates.
//          On error: err pulse, busy=0 the next cycle, FSM returns to IDLE, stage outputs are held.
//  ISSUE:  pass_start pulses for one cycle. Radix follows the order: all stage5 passes, then stage3, then stage2.
//          pass_radix and pass_idx are updated in the same cycle as pass_start.
//          The first ISSUE occurs the cycle after factoring ends.
//  WAIT:   the watchdog counts from 0, cleared on each pass_start.
//          - eng_done at cycle t with passes remaining -> next pass_start at t+1.
//          - eng_done on the last pass -> DONE at t+1: fft_done pulses, pass_radix goes to 00. busy=0 at t+2.
//          - Watchdog reaching TIMEOUT with no eng_done -> err pulse, FSM returns to IDLE, pass_radix goes to 00.
//  Ignored inputs:
//          - eng_done outside WAIT. No effect, no error.
//          - start while busy.
//          - start and eng_done in the same IDLE cycle: start is accepted, eng_done is ignored.
//          - eng_done coinciding with the watchdog expiry: eng_done wins.
//  Stage outputs remain valid and stable from the end of factoring until the next accepted start.
//  Reset asserted mid-job returns everything to reset values immediately. No fft_done or err is produced.
// TESTING
//  n_last=11 (N=12) -> stage2=2, stage3=1, stage5=0. Passes r3,r2,r2 with idx 0..2.
//    fft_done one cycle after the 3rd eng_done.
//  n_last=1199 (N=1200) -> stage2=4, stage3=1, stage5=2. Passes 5,5,3,2,2,2,2. err never asserted.
//  n_last=6 (N=7) -> err pulse. No pass_start. busy returns to 0. A following start with n_last=59 completes normally.
//  n_last=624 (N=625=5^4) -> err pulse on stage5 overflow. No pass_start.
//  N=60 with eng_done withheld on pass 1 -> err exactly TIMEOUT cycles after that pass_start. FSM back in IDLE.
//  rst low during WAIT of pass 2, then high -> all outputs 0. Stray eng_done and start-while-busy ignored.

Source files
------------

// File: rtl/fft_pass_scheduler.sv
// Pass sequencer for the mixed-radix FFT: factorises N = n_last+1 into 2^a*3^b*5^c,
// then issues one pass command per radix stage (r5s, then r3s, then r2s) under a per-pass watchdog.
module fft_pass_scheduler #(
  parameter int N_W     = 11,
  parameter int TO_W    = 13,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n_last,
  input  logic           eng_done,
  output logic           busy,
  output logic [3:0]     stage2,
  output logic [2:0]     stage3,
  output logic [1:0]     stage5,
  output logic           pass_start,
  output logic [1:0]     pass_radix,
  output logic [3:0]     pass_idx,
  output logic           fft_done,
  output logic           err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FACTOR, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {RAD_NONE = 2'b00, RAD_2 = 2'b01, RAD_3 = 2'b10, RAD_5 = 2'b11} radix_t;
  typedef logic [N_W:0] m_t;

  localparam m_t              M_ONE   = m_t'(1);
  localparam m_t              M_THREE = m_t'(3);
  localparam m_t              M_FIVE  = m_t'(5);
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  m_t              m;
  logic            ovf5;
  logic [4:0]      issued;
  logic [TO_W-1:0] wd;

  logic [4:0] end5, end3, total;
  radix_t     next_radix;
  logic       div2, div3, div5;
  logic       size_bad, factor_ok, issue_now;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    end5  = {3'b000, stage5};
    end3  = end5 + {2'b00, stage3};
    total = end3 + {1'b0, stage2};

    next_radix = RAD_2;
    if (issued < end5)      next_radix = RAD_5;
    else if (issued < end3) next_radix = RAD_3;

    div2 = ~m[0];
    div3 = (m % M_THREE) == '0;
    div5 = (m % M_FIVE) == '0;

    // Residual not fully factored, a saturated radix-5 count, or N == 1 (nothing stripped).
    size_bad  = (m != M_ONE) || ovf5 || (total == '0);
    factor_ok = (state == S_FACTOR) && !div2 && !div3 && !div5 && !size_bad;
    issue_now = factor_ok || ((state == S_WAIT) && eng_done && (issued != total));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      m          <= '0;
      ovf5       <= 1'b0;
      issued     <= '0;
      wd         <= '0;
      busy       <= 1'b0;
      stage2     <= '0;
      stage3     <= '0;
      stage5     <= '0;
      pass_start <= 1'b0;
      pass_radix <= RAD_NONE;
      pass_idx   <= '0;
      fft_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      pass_start <= 1'b0;
      fft_done   <= 1'b0;
      err        <= 1'b0;

      case (state)
        S_IDLE: begin
          busy <= 1'b0;
          // busy is still high for the one IDLE cycle after an abort, which blocks a same-cycle restart.
          if (start && !busy) begin
            m      <= {1'b0, n_last} + M_ONE;
            stage2 <= '0;
            stage3 <= '0;
            stage5 <= '0;
            ovf5   <= 1'b0;
            issued <= '0;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end

        S_LOAD: state <= S_FACTOR;

        S_FACTOR: begin
          if (div2) begin
            m      <= m >> 1;
            stage2 <= stage2 + 4'd1;
          end else if (div3) begin
            m      <= m / M_THREE;
            stage3 <= stage3 + 3'd1;
          end else if (div5) begin
            m <= m / M_FIVE;
            if (stage5 == 2'd3) ovf5   <= 1'b1;
            else                stage5 <= stage5 + 2'd1;
          end else if (size_bad) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wd    <= wd + 1'b1;
          state <= S_WAIT;
        end

        S_WAIT: begin
          wd <= wd + 1'b1;
          if (eng_done) begin
            if (issued == total) begin
              fft_done   <= 1'b1;
              pass_radix <= RAD_NONE;
              state      <= S_DONE;
            end else begin
              state <= S_ISSUE;
            end
          end else if (wd == WD_LAST) begin
            err        <= 1'b1;
            pass_radix <= RAD_NONE;
            state      <= S_IDLE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase

      if (issue_now) begin
        pass_start <= 1'b1;
        pass_radix <= next_radix;
        pass_idx   <= issued[3:0];
        issued     <= issued + 5'd1;
        wd         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_pass_scheduler.sv
// Self-checking bench for fft_pass_scheduler: a scoreboard of expected pass commands is filled per job
// and drained by a monitor on every pass_start; latencies and pulses are checked inline.
`timescale 1ns/1ps
module tb_fft_pass_scheduler;

  localparam int N_W     = 11;
  localparam int TO_W    = 13;
  localparam int TIMEOUT = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N_W-1:0] n_last;
  logic           eng_done;
  logic           busy;
  logic [3:0]     stage2;
  logic [2:0]     stage3;
  logic [1:0]     stage5;
  logic           pass_start;
  logic [1:0]     pass_radix;
  logic [3:0]     pass_idx;
  logic           fft_done;
  logic           err;

  typedef struct packed {
    logic [1:0] radix;
    logic [3:0] idx;
  } pass_t;

  pass_t sb[$];
  pass_t mon_e;
  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;

  always #5 clk = ~clk;

  fft_pass_scheduler #(.N_W(N_W), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_last     (n_last),
    .eng_done   (eng_done),
    .busy       (busy),
    .stage2     (stage2),
    .stage3     (stage3),
    .stage5     (stage5),
    .pass_start (pass_start),
    .pass_radix (pass_radix),
    .pass_idx   (pass_idx),
    .fft_done   (fft_done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({busy, stage2, stage3, stage5, pass_start, pass_radix, pass_idx, fft_done, err});
  endfunction

  // Reference factorisation of N: stage counts, total strips (unsaturated) and legality.
  function automatic void model(input int n_in, output int a, output int b, output int c,
                                output int strips, output bit ok);
    int n;
    n = n_in;
    a = 0; b = 0; c = 0;
    while (n % 2 == 0) begin n = n / 2; a++; end
    while (n % 3 == 0) begin n = n / 3; b++; end
    while (n % 5 == 0) begin n = n / 5; c++; end
    strips = a + b + c;
    ok     = (n == 1) && (c <= 3) && (strips > 0);
    if (c > 3) c = 3;
  endfunction

  // Monitor: every pass_start must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (err) err_cnt++;
      if (pass_start) begin
        if (sb.size() == 0) begin
          check("pass_unexpected", 32'(sb.size()), 1);
        end else begin
          mon_e = sb.pop_front();
          check("pass_radix", 32'(pass_radix), 32'(mon_e.radix));
          check("pass_idx", 32'(pass_idx), 32'(mon_e.idx));
        end
      end
    end
  end

  // hang_idx >= 0 withholds eng_done on that pass; hang_reset pulls rst there instead of timing out.
  task automatic run_job(input int n, input int hang_idx, input bit hang_reset, input bit stray);
    int a, b, c, strips, t, np, err0;
    bit ok;
    logic [1:0] r;
    model(n + 1, a, b, c, strips, ok);
    np = a + b + c;
    if (ok) begin
      for (int i = 0; i < np; i++) begin
        if (hang_idx < 0 || i <= hang_idx) begin
          r = (i < c) ? 2'b11 : (i < c + b) ? 2'b10 : 2'b01;
          sb.push_back('{radix: r, idx: 4'(i)});
        end
      end
    end
    err0 = err_cnt;

    start    = 1'b1;
    n_last   = N_W'(n);
    eng_done = stray;
    @(negedge clk);
    start    = 1'b0;
    eng_done = 1'b0;
    check("busy_rise", 32'(busy), 1);

    t = 1;
    while (!pass_start && !err && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("stage2", 32'(stage2), 32'(a));
    check("stage3", 32'(stage3), 32'(b));
    check("stage5", 32'(stage5), 32'(c));

    if (!ok) begin
      check("err_latency", 32'(t), 32'(3 + strips));
      check("err_pulse", 32'(err), 1);
      check("err_no_pass", 32'(pass_start), 0);
      @(negedge clk);
      check("busy_fall_err", 32'(busy), 0);
      check("err_width", 32'(err), 0);
      return;
    end

    check("issue_latency", 32'(t), 32'(3 + np));
    for (int p = 0; p < np; p++) begin
      if (p == hang_idx) begin
        if (hang_reset) begin
          repeat (2) @(negedge clk);
          rst = 1'b0;
          #1;
          check("rst_outputs", all_outputs(), 0);
          @(negedge clk);
          rst = 1'b1;
          sb.delete();
          @(negedge clk);
          check("post_rst_outputs", all_outputs(), 0);
          return;
        end
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!err && t < TIMEOUT + 10);
        check("wd_latency", 32'(t), TIMEOUT);
        check("wd_radix", 32'(pass_radix), 0);
        @(negedge clk);
        check("busy_fall_wd", 32'(busy), 0);
        check("sb_empty_wd", 32'(sb.size()), 0);
        return;
      end
      @(negedge clk);
      start  = 1'b1;
      n_last = '0;
      @(negedge clk);
      start = 1'b0;
      repeat (p % 3) @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
      if (p < np - 1) begin
        check("next_issue", 32'(pass_start), 1);
      end else begin
        check("fft_done", 32'(fft_done), 1);
        check("done_radix", 32'(pass_radix), 0);
        @(negedge clk);
        check("busy_fall", 32'(busy), 0);
        check("done_width", 32'(fft_done), 0);
        check("stage2_hold", 32'(stage2), 32'(a));
      end
    end
    check("sb_empty", 32'(sb.size()), 0);
    check("no_err", 32'(err_cnt), 32'(err0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    eng_done = 1'b0;
    n_last   = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b1;
    @(negedge clk);

    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    check("stray_idle_busy", 32'(busy), 0);
    check("stray_idle_err", 32'(err), 0);

    run_job(11, -1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    run_job(1199, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(6, -1, 1'b0, 1'b0);
    run_job(59, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(624, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(59, 1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(59, 2, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    run_job(2047, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(0, -1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    run_job(59, -1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
